lfsr: RTL and testbench
=======================

// Module: lfsr
// PURPOSE
// - Parameterisable Fibonacci LFSR (XNOR feedback) producing a NUM_BITS-wide pseudo-random word.
// - Generates the maze wall-enable vector: one bit per grid block.
//   The top level samples the output word into its wall register on reset.
// - Built-in step-rate divider, so the sequence advances every STEP_DIV enabled in_clk cycles.
// - Parallel seed load and a sequence-done flag.
// PARAMETERS
// NUM_BITS  25  register width; legal 3..32 (maximal-length tap table below)
// STEP_DIV  1   in_clk cycles per LFSR step while enabled; legal 1..2^32-1
// PORTS
// in_clk     in   1         system clock; all state on rising edge
// reset      in   1         synchronous, active-high
// enable     in   1         step enable; low freezes register and divider
// seed_dv    in   1         seed-valid strobe; loads seed_data
// seed_data  in   NUM_BITS  seed value / done-compare value
// lfsr_data  out  NUM_BITS  current register contents (registered)
// lfsr_done  out  1         high while lfsr_data == seed_data (combinational compare)
// BEHAVIOUR
// - Priority each edge: reset > seed_dv > step > hold.
// - reset: q <= 0, divider count <= 0; lfsr_data = 0 on the next cycle.
// - seed_dv=1 (enable ignored): q <= seed_data, divider count <= 0.
// - Divider: while enable=1, count increments each cycle.
//   When count == STEP_DIV-1: count <= 0 and one step occurs that same edge.
//   STEP_DIV=1 -> step every enabled cycle.
//   enable=0 -> count and q hold.
// - Step (q is q[NUM_BITS-1:0]):
//   - q <= {q[NUM_BITS-2:0], fb}.
//   - fb = XNOR of tapped bits; tap t means bit q[t-1].
// - Taps t (per NUM_BITS):
//   - 3:3,2  4:4,3  5:5,3  6:6,5  7:7,6  8:8,6,5,4  9:9,5  10:10,7  11:11,9
//   - 12:12,6,4,1  13:13,4,3,1  14:14,5,3,1  15:15,14  16:16,15,13,4  17:17,14
//   - 18:18,11  19:19,6,2,1  20:20,17  21:21,19  22:22,21  23:23,18  24:24,23,22,17
//   - 25:25,22  26:26,6,2,1  27:27,5,2,1  28:28,25  29:29,27  30:30,6,4,1
//   - 31:31,28  32:32,22,2,1
// - Period is 2^NUM_BITS-1 from any state except all-ones.
//   All-ones is the XNOR lock-up state: once loaded it stays all-ones; no auto-recovery.
// - All-zeros is a legal state (reset value) and lies on the maximal sequence.
// - lfsr_done = (lfsr_data == seed_data), purely combinational; no latency, no sticky state.
//   Asserts immediately after a seed load and again after every full period.
// - Reset mid-divide discards the partial count; seed_dv mid-divide restarts the count.
// - No handshake; the output is valid every cycle.
// TESTING
// 1 NUM_BITS=25, STEP_DIV=1:
//   - reset 1 cycle -> lfsr_data=0x0000000.
//   - enable=1 -> 0x0000001, 0x0000003, 0x0000007, ... (ones fill in from bit 0).
// 2 Continuing test 1:
//   - after 22 steps -> 0x03FFFFF.
//   - 23rd step -> 0x07FFFFE (fb=0 since q[21]=1, q[24]=0).
// 3 seed_dv=1 with seed_data=0x1D16B5F, enable=0 -> next cycle lfsr_data=0x1D16B5F, lfsr_done=1.
//   - enable=1 one step -> lfsr_done=0.
// 4 STEP_DIV=4, enable=1 from reset:
//   - lfsr_data changes only on every 4th edge (0 -> 1 after the 4th edge, -> 3 after the 8th).
//   - Drop enable for 3 cycles mid-count -> step delayed by exactly 3 cycles.
// 5 NUM_BITS=5, STEP_DIV=1, seed 0 loaded:
//   - lfsr_done reasserts after exactly 31 steps.
//   - All 31 values except 0x1F are visited once.
// 6 Lock-up and priority:
//   - Seed 0x1FFFFFF -> value stays 0x1FFFFFF under enable.
//   - reset and seed_dv together -> 0.

Source files
------------

// File: rtl/lfsr.sv
// Fibonacci LFSR with XNOR feedback, a built-in step-rate divider, parallel seed load
// and a done flag that is high while the register matches the seed word.
module lfsr #(
  parameter int unsigned NUM_BITS = 25,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                in_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] seed_data,
  output logic [NUM_BITS-1:0] lfsr_data,
  output logic                lfsr_done
);

  localparam int unsigned CNT_W = 32;

  // Single-bit mask for tap t, where tap t selects register bit t-1.
  function automatic logic [31:0] tap_bit(input int unsigned t);
    return 32'd1 << (t - 1);
  endfunction

  // Maximal-length XNOR tap sets, indexed by register width.
  function automatic logic [31:0] tap_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAP_MASK_W = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS       = TAP_MASK_W[NUM_BITS-1:0];
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STEP_DIV - 1);

  logic [NUM_BITS-1:0] q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fb;

  // XNOR feedback keeps all-zeros on the sequence; all-ones is the lock-up state.
  assign fb = ~^(q_q & TAPS);

  // Next state: seed load beats stepping; the divider only runs while enabled.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (seed_dv) begin
      q_d   = seed_data;
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        q_d   = {q_q[NUM_BITS-2:0], fb};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign lfsr_data = q_q;
  assign lfsr_done = (q_q == seed_data);

endmodule

// File: tb/tb_lfsr.sv
// Directed checks of the LFSR: fill pattern, seed/done, step divider with enable gaps,
// full period at 5 bits, all-ones lock-up and reset-over-seed priority.
module tb_lfsr;

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Instance A: 25 bits, step every enabled cycle
  logic        a_reset = 1'b0, a_enable = 1'b0, a_seed_dv = 1'b0;
  logic [24:0] a_seed_data = '0;
  logic [24:0] a_lfsr_data;
  logic        a_lfsr_done;

  // Instance B: 25 bits, step every 4th enabled cycle
  logic        b_reset = 1'b0, b_enable = 1'b0, b_seed_dv = 1'b0;
  logic [24:0] b_seed_data = '0;
  logic [24:0] b_lfsr_data;
  logic        b_lfsr_done;

  // Instance C: 5 bits, step every enabled cycle
  logic        c_reset = 1'b0, c_enable = 1'b0, c_seed_dv = 1'b0;
  logic [4:0]  c_seed_data = '0;
  logic [4:0]  c_lfsr_data;
  logic        c_lfsr_done;

  lfsr #(.NUM_BITS(25), .STEP_DIV(1)) u_a (
    .in_clk(in_clk), .reset(a_reset), .enable(a_enable), .seed_dv(a_seed_dv),
    .seed_data(a_seed_data), .lfsr_data(a_lfsr_data), .lfsr_done(a_lfsr_done));

  lfsr #(.NUM_BITS(25), .STEP_DIV(4)) u_b (
    .in_clk(in_clk), .reset(b_reset), .enable(b_enable), .seed_dv(b_seed_dv),
    .seed_data(b_seed_data), .lfsr_data(b_lfsr_data), .lfsr_done(b_lfsr_done));

  lfsr #(.NUM_BITS(5), .STEP_DIV(1)) u_c (
    .in_clk(in_clk), .reset(c_reset), .enable(c_enable), .seed_dv(c_seed_dv),
    .seed_data(c_seed_data), .lfsr_data(c_lfsr_data), .lfsr_done(c_lfsr_done));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle outputs away from it.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  logic [4:0]  c_first [5] = '{5'h01, 5'h03, 5'h07, 5'h0E, 5'h1C};
  logic [31:0] seen;
  int          dups;

  initial begin
    #1;
    // Reset all instances together.
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    tick();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    chk("a_reset_data", 32'(a_lfsr_data), 32'h0);
    chk("a_reset_done", 32'(a_lfsr_done), 32'h1);
    chk("b_reset_data", 32'(b_lfsr_data), 32'h0);

    // Ones fill in from bit 0 for 22 steps, then fb=0 on the 23rd.
    a_enable = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk($sformatf("a_fill_%0d", i), 32'(a_lfsr_data), (32'd1 << i) - 32'd1);
    end
    tick();
    chk("a_step23", 32'(a_lfsr_data), 32'h07FFFFE);

    // Seed load with enable low, then one step clears done.
    a_enable = 1'b0; a_seed_dv = 1'b1; a_seed_data = 25'h1D16B5F;
    tick();
    a_seed_dv = 1'b0;
    chk("a_seed_data", 32'(a_lfsr_data), 32'h1D16B5F);
    chk("a_seed_done", 32'(a_lfsr_done), 32'h1);
    tick();
    chk("a_hold_data", 32'(a_lfsr_data), 32'h1D16B5F);
    a_enable = 1'b1;
    tick();
    a_enable = 1'b0;
    chk("a_seed_step", 32'(a_lfsr_data), 32'h1A2D6BE);
    chk("a_seed_step_done", 32'(a_lfsr_done), 32'h0);

    // Divide-by-4: steps land on edges 4 and, after a 3-cycle enable gap, 11.
    b_enable = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("b_div_e%0d", e), 32'(b_lfsr_data), (e == 4) ? 32'h1 : 32'h0);
    end
    tick(); tick();
    chk("b_div_e6", 32'(b_lfsr_data), 32'h1);
    b_enable = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk($sformatf("b_gap_%0d", g), 32'(b_lfsr_data), 32'h1);
    end
    b_enable = 1'b1;
    tick();
    chk("b_div_e10", 32'(b_lfsr_data), 32'h1);
    tick();
    chk("b_div_e11", 32'(b_lfsr_data), 32'h3);
    // Seed mid-divide restarts the count: next step four enabled edges later.
    tick();
    b_seed_dv = 1'b1; b_seed_data = 25'h0000003;
    tick();
    b_seed_dv = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("b_reseed_e%0d", e), 32'(b_lfsr_data), (e == 4) ? 32'h7 : 32'h3);
    end
    b_enable = 1'b0;

    // 5-bit full period from seed 0.
    c_seed_dv = 1'b1; c_seed_data = 5'h00;
    tick();
    c_seed_dv = 1'b0;
    chk("c_seed_done", 32'(c_lfsr_done), 32'h1);
    seen = 32'h0; dups = 0;
    c_enable = 1'b1;
    for (int s = 1; s <= 31; s++) begin
      tick();
      if (s <= 5) chk($sformatf("c_val_%0d", s), 32'(c_lfsr_data), 32'(c_first[s-1]));
      chk($sformatf("c_done_%0d", s), 32'(c_lfsr_done), (s == 31) ? 32'h1 : 32'h0);
      if (seen[c_lfsr_data]) dups++;
      seen[c_lfsr_data] = 1'b1;
    end
    c_enable = 1'b0;
    chk("c_dups", 32'(dups), 32'h0);
    chk("c_visited", seen, 32'h7FFFFFFF);

    // All-ones lock-up under enable.
    a_seed_dv = 1'b1; a_seed_data = 25'h1FFFFFF;
    tick();
    a_seed_dv = 1'b0; a_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("a_lock_%0d", k), 32'(a_lfsr_data), 32'h1FFFFFF);
    end

    // Reset beats a simultaneous seed load.
    a_reset = 1'b1; a_seed_dv = 1'b1; a_seed_data = 25'h1234567;
    tick();
    a_reset = 1'b0; a_seed_dv = 1'b0; a_enable = 1'b0;
    chk("a_rst_over_seed", 32'(a_lfsr_data), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
